// File: rtl/rect_fill_engine_pkg.sv
// Shared constants, request record and engine state encoding for the rectangle fill engine.
package rect_fill_engine_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE   = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN  = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN   = 3'b011;
  localparam logic [COLOUR_W-1:0] RED    = 3'b100;
  localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE  = 3'b111;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
  } rect_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } engine_state_t;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Request handshake and pixel-write bundle between a client and the fill engine.
interface rect_fill_engine_if;
  import rect_fill_engine_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [X_W-1:0]      req_w;
  logic [Y_W-1:0]      req_h;
  logic [COLOUR_W-1:0] req_colour;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_plot;
  logic                done;
  logic                busy;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour,
    input  req_ready, pix_x, pix_y, pix_colour, pix_plot, done, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour,
    output req_ready, pix_x, pix_y, pix_colour, pix_plot, done, busy
  );

endinterface

// File: rtl/rect_req_fifo.sv
// Rectangle request queue; an extra pointer bit separates full from empty.
module rect_req_fifo
  import rect_fill_engine_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      resetn,
  input  logic      i_push,
  input  rect_req_t i_data,
  input  logic      i_pop,
  output rect_req_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  rect_req_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      else           r_wr_ptr <= r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      else           r_rd_ptr <= r_rd_ptr;
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Queued rectangle filler: walks each rectangle row-major, clips off-screen pixels, pulses done at the end.
module rect_fill_engine #(
  parameter int SCREEN_W   = rect_fill_engine_pkg::SCREEN_W,
  parameter int SCREEN_H   = rect_fill_engine_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  rect_fill_engine_if.slave bus
);
  import rect_fill_engine_pkg::*;

  localparam logic [8:0] LP_X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] LP_Y_LIM = 8'(SCREEN_H);

  rect_req_t           w_wr_data;
  rect_req_t           w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_last_col;
  logic                w_last_row;
  logic                w_visible;

  engine_state_t       r_state;
  rect_req_t           r_req;
  logic [X_W-1:0]      r_col;
  logic [Y_W-1:0]      r_row;
  logic                r_null;
  logic                r_s_valid;
  logic                r_s_last;
  logic [8:0]          r_s_x;
  logic [7:0]          r_s_y;
  logic [COLOUR_W-1:0] r_s_colour;
  logic [X_W-1:0]      r_pix_x;
  logic [Y_W-1:0]      r_pix_y;
  logic [COLOUR_W-1:0] r_pix_colour;
  logic                r_pix_plot;
  logic                r_done;

  assign w_wr_data  = {bus.req_x, bus.req_y, bus.req_w, bus.req_h, bus.req_colour};
  assign w_push     = bus.req_valid && !w_full;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_last_col = (r_col == (r_req.w - 8'd1));
  assign w_last_row = (r_row == (r_req.h - 7'd1));
  assign w_visible  = r_s_valid && (r_s_x < LP_X_LIM) && (r_s_y < LP_Y_LIM);

  assign bus.req_ready  = !w_full;
  assign bus.busy       = !w_empty || (r_state != ST_IDLE);
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_colour = r_pix_colour;
  assign bus.pix_plot   = r_pix_plot;
  assign bus.done       = r_done;

  rect_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_wr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Engine FSM plus one staging register; an empty rectangle rides r_null so its done keeps the normal latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_null     <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_last   <= 1'b0;
      r_s_x      <= '0;
      r_s_y      <= '0;
      r_s_colour <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_s_valid <= 1'b0;
          r_s_last  <= r_null;
          if (!w_empty) begin
            r_req <= w_head;
            r_col <= '0;
            r_row <= '0;
            if ((w_head.w == 8'd0) || (w_head.h == 7'd0)) begin
              r_null  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_null  <= 1'b0;
              r_state <= ST_DRAW;
            end
          end else begin
            r_null  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DRAW: begin
          r_null     <= 1'b0;
          r_s_valid  <= 1'b1;
          r_s_x      <= {1'b0, r_req.x} + {1'b0, r_col};
          r_s_y      <= {1'b0, r_req.y} + {1'b0, r_row};
          r_s_colour <= r_req.colour;
          r_s_last   <= w_last_col && w_last_row;
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_row   <= r_row + 7'd1;
              r_state <= ST_DRAW;
            end
          end else begin
            r_col   <= r_col + 8'd1;
            r_state <= ST_DRAW;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_null    <= 1'b0;
          r_s_valid <= 1'b0;
          r_s_last  <= 1'b0;
        end
      endcase
    end
  end

  // Registered pixel port; coordinates and colour hold across clipped or idle cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_colour <= '0;
      r_pix_plot   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pix_plot <= w_visible;
      r_done     <= r_s_last;
      if (w_visible) begin
        r_pix_x      <= r_s_x[X_W-1:0];
        r_pix_y      <= r_s_y[Y_W-1:0];
        r_pix_colour <= r_s_colour;
      end else begin
        r_pix_x      <= r_pix_x;
        r_pix_y      <= r_pix_y;
        r_pix_colour <= r_pix_colour;
      end
    end
  end

endmodule
